vreg_wb_arbiter: RTL and testbench

- Arbitrates the single vector-register-file write port between the three writeback sources: arithmetic stage, memory (VLSU) and scalar replicator.
- Each requester asks for a burst of 1..MAX_BEATS consecutive vector registers starting at vd (LMUL grouping). The arbiter locks to one owner per burst, sequences the register addresses and drives a registered write port tagged with the source.
- Sits between the PE array / VLSU / scalar replicator and the vector register file. Replaces the static writeback-source mux select.

---
 rtl/vreg_wb_arbiter_pkg.sv | 16 +
 rtl/vreg_wb_arbiter_rr_pick.sv | 17 +
 rtl/vreg_wb_arbiter.sv | 118 +++++++++++
 tb/tb_vreg_wb_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vreg_wb_arbiter_pkg.sv
// vreg_wb_arbiter_pkg: shared types for the vector-register writeback arbiter.
package vreg_wb_arbiter_pkg;
    localparam int VREG_WB_NUM_SRC = 3;

    typedef enum logic [1:0] {
        WB_SRC_ARITH  = 2'd0,
        WB_SRC_MEMORY = 2'd1,
        WB_SRC_SCALAR = 2'd2
    } vreg_wb_src_t;

    typedef enum logic {WB_ARB_IDLE, WB_ARB_BURST} wb_arb_state_t;

    function automatic vreg_wb_src_t src_next(input vreg_wb_src_t s);
        return (s == WB_SRC_ARITH) ? WB_SRC_MEMORY : (s == WB_SRC_MEMORY) ? WB_SRC_SCALAR : WB_SRC_ARITH;
    endfunction
endpackage

// File: rtl/vreg_wb_arbiter_rr_pick.sv
// vreg_wb_rr_pick: combinational 3-way round-robin picker, first valid source at or after the pointer.
module vreg_wb_rr_pick
    import vreg_wb_arbiter_pkg::*;
(
    input  logic [2:0] i_valid,
    input  logic [1:0] i_rr_ptr,
    output logic       o_grant_valid,
    output logic [1:0] o_grant_idx
);
    vreg_wb_src_t w_c0, w_c1, w_c2;

    assign w_c0          = vreg_wb_src_t'(i_rr_ptr);
    assign w_c1          = src_next(w_c0);
    assign w_c2          = src_next(w_c1);
    assign o_grant_valid = |i_valid;
    assign o_grant_idx   = i_valid[w_c0] ? w_c0 : i_valid[w_c1] ? w_c1 : w_c2;
endmodule

// File: rtl/vreg_wb_arbiter.sv
// vreg_wb_arbiter: locks the vector register file write port to one writeback source per burst,
// sequencing consecutive register addresses and registering the write with its source tag.
module vreg_wb_arbiter
    import vreg_wb_arbiter_pkg::*;
#(
    parameter int VLEN      = 32,
    parameter int MAX_BEATS = 8,
    parameter int NREG      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [2:0]               req_i,
    input  logic [2:0][4:0]          vd_i,
    input  logic [2:0][3:0]          nbeats_i,
    input  logic [2:0]               beat_valid_i,
    input  logic [2:0][VLEN-1:0]     beat_data_i,
    input  logic [2:0][VLEN/8-1:0]   beat_be_i,
    output logic [2:0]               beat_ready_o,
    output logic [2:0]               done_o,
    output logic [2:0]               err_o,
    input  logic                     abort_i,
    output logic                     vr_we_o,
    output logic [4:0]               vr_waddr_o,
    output logic [VLEN-1:0]          vr_wdata_o,
    output logic [VLEN/8-1:0]        vr_wbe_o,
    output logic [1:0]               vr_wsrc_o,
    output logic                     busy_o
);
    wb_arb_state_t     r_state, w_state_nx;
    vreg_wb_src_t      r_owner, r_rr_ptr, r_wsrc;
    logic [4:0]        r_base, r_waddr;
    logic [3:0]        r_rem, r_idx;
    logic              r_we;
    logic [VLEN-1:0]   r_wdata;
    logic [VLEN/8-1:0] r_wbe;
    logic [2:0]        r_done, r_err, w_ok;
    logic              w_gv, w_grant, w_accept, w_last;
    logic [1:0]        w_gidx;

    // 6-bit end-of-group compare so vd+nbeats past the last register is rejected, not wrapped
    always_comb begin
        for (int i = 0; i < VREG_WB_NUM_SRC; i++)
            w_ok[i] = (nbeats_i[i] != 4'd0) && (nbeats_i[i] <= 4'(MAX_BEATS))
                   && (({1'b0, vd_i[i]} + {2'b0, nbeats_i[i]}) <= 6'(NREG));
    end

    vreg_wb_rr_pick u_pick (
        .i_valid       (req_i & w_ok),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant_valid (w_gv),
        .o_grant_idx   (w_gidx)
    );

    assign w_grant      = (r_state == WB_ARB_IDLE) && w_gv && !abort_i;
    assign w_accept     = (r_state == WB_ARB_BURST) && beat_valid_i[r_owner] && !abort_i;
    assign w_last       = (r_idx + 4'd1) == r_rem;
    assign beat_ready_o = ((r_state == WB_ARB_BURST) && !abort_i) ? (3'b001 << r_owner) : 3'b000;
    assign busy_o       = r_state != WB_ARB_IDLE;
    assign vr_we_o      = r_we;
    assign vr_waddr_o   = r_waddr;
    assign vr_wdata_o   = r_wdata;
    assign vr_wbe_o     = r_wbe;
    assign vr_wsrc_o    = r_wsrc;
    assign done_o       = r_done;
    assign err_o        = r_err;

    always_comb begin
        w_state_nx = r_state;
        if (r_state == WB_ARB_IDLE)
            w_state_nx = w_grant ? WB_ARB_BURST : WB_ARB_IDLE;
        else if (abort_i || (w_accept && w_last))
            w_state_nx = WB_ARB_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= WB_ARB_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner  <= WB_SRC_ARITH;
            r_rr_ptr <= WB_SRC_ARITH;
            r_base   <= '0;
            r_rem    <= '0;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wbe    <= '0;
            r_wsrc   <= WB_SRC_ARITH;
            r_done   <= '0;
            r_err    <= '0;
        end else begin
            r_we   <= w_accept;
            r_done <= (w_accept && w_last) ? (3'b001 << r_owner) : 3'b000;
            r_err  <= (r_state == WB_ARB_IDLE) ? (req_i & ~w_ok) : 3'b000;
            if (w_grant) begin
                r_owner <= vreg_wb_src_t'(w_gidx);
                r_base  <= vd_i[w_gidx];
                r_rem   <= nbeats_i[w_gidx];
                r_idx   <= '0;
            end
            if (w_accept) begin
                r_idx   <= r_idx + 4'd1;
                r_waddr <= r_base + {1'b0, r_idx};
                r_wdata <= beat_data_i[r_owner];
                r_wbe   <= beat_be_i[r_owner];
                r_wsrc  <= r_owner;
            end
            // an aborted burst leaves the pointer alone so the same source gets first look again
            if (w_accept && w_last)
                r_rr_ptr <= src_next(r_owner);
        end
    end
endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// tb_vreg_wb_arbiter: table-driven bursts plus hand-written corner sequences; expected writes
// are queued when beats are driven and popped when the register-file write port fires.
module tb_vreg_wb_arbiter;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        req_i = '0;
    logic [2:0][4:0]   vd_i = '0;
    logic [2:0][3:0]   nbeats_i = '0;
    logic [2:0]        beat_valid_i = '0;
    logic [2:0][31:0]  beat_data_i = '0;
    logic [2:0][3:0]   beat_be_i = '0;
    logic              abort_i = 1'b0;
    logic [2:0]        beat_ready_o, done_o, err_o;
    logic              vr_we_o, busy_o;
    logic [4:0]        vr_waddr_o;
    logic [31:0]       vr_wdata_o;
    logic [3:0]        vr_wbe_o;
    logic [1:0]        vr_wsrc_o;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [1:0]  src;
        bit          done;
        int          cyc;
    } exp_t;

    typedef struct {
        int         src;
        logic [4:0] vd;
        logic [3:0] nb;
        bit         err;
    } vec_t;

    exp_t exp_q[$];
    exp_t me;
    vec_t tbl[8];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    vreg_wb_arbiter #(.VLEN(32), .MAX_BEATS(8), .NREG(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req_i),
        .vd_i         (vd_i),
        .nbeats_i     (nbeats_i),
        .beat_valid_i (beat_valid_i),
        .beat_data_i  (beat_data_i),
        .beat_be_i    (beat_be_i),
        .beat_ready_o (beat_ready_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .abort_i      (abort_i),
        .vr_we_o      (vr_we_o),
        .vr_waddr_o   (vr_waddr_o),
        .vr_wdata_o   (vr_wdata_o),
        .vr_wbe_o     (vr_wbe_o),
        .vr_wsrc_o    (vr_wsrc_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] bdata(input int s, input int k);
        return {16'hAAAA + 16'(s) * 16'h1111, 16'(k + 1)};
    endfunction

    function automatic logic [3:0] bbe(input int s, input int k);
        return 4'hF ^ 4'(k + s);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_we"}, vr_we_o, 0);
        chk({t, "_waddr"}, vr_waddr_o, 0);
        chk({t, "_wdata"}, vr_wdata_o, 0);
        chk({t, "_wbe"}, vr_wbe_o, 0);
        chk({t, "_wsrc"}, vr_wsrc_o, 0);
        chk({t, "_done"}, done_o, 0);
        chk({t, "_err"}, err_o, 0);
        chk({t, "_busy"}, busy_o, 0);
        chk({t, "_ready"}, beat_ready_o, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (vr_we_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write (cycle %0d)", vr_waddr_o, vr_wdata_o, cyc);
                end else begin
                    me = exp_q.pop_front();
                    chk("wr_addr", vr_waddr_o, me.addr);
                    chk("wr_data", vr_wdata_o, me.data);
                    chk("wr_be", vr_wbe_o, me.be);
                    chk("wr_src", vr_wsrc_o, me.src);
                    chk("wr_done", done_o, me.done ? (3'b001 << me.src) : 3'b000);
                    chk("wr_cycle", cyc, me.cyc);
                end
            end else begin
                chk("idle_done", done_o, 0);
            end
        end
    end

    task automatic run_burst(input int s, input logic [4:0] vd, input logic [3:0] n, input logic [15:0] pat, input bit exp_err);
        int   k, p;
        exp_t e;
        req_i[s] = 1'b1;
        vd_i[s] = vd;
        nbeats_i[s] = n;
        @(posedge clk); #1;
        req_i[s] = 1'b0;
        chk("err", err_o, exp_err ? (3'b001 << s) : 3'b000);
        chk("busy_after_req", busy_o, !exp_err);
        if (exp_err) begin
            @(posedge clk); #1;
            chk("err_clear", err_o, 0);
            return;
        end
        k = 0;
        p = 0;
        while (k < int'(n) && p < 40) begin
            beat_valid_i[s] = pat[p % 16];
            beat_data_i[s] = bdata(s, k);
            beat_be_i[s] = bbe(s, k);
            @(negedge clk);
            chk("ready", beat_ready_o, 3'b001 << s);
            if (beat_valid_i[s]) begin
                e = '{addr: vd + 5'(k), data: bdata(s, k), be: bbe(s, k), src: 2'(s), done: (k == int'(n) - 1), cyc: cyc + 1};
                exp_q.push_back(e);
                k++;
            end
            @(posedge clk); #1;
            p++;
        end
        beat_valid_i[s] = 1'b0;
        if (k < int'(n)) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: got %0d beats expected %0d", k, n);
        end
        chk("busy_after_burst", busy_o, 0);
        @(posedge clk); #1;
    endtask

    // every source asks for one register; writes land every second cycle in round-robin order
    task automatic rr_seq(input logic [2:0] mask, input int nb, input int first);
        int   c0, cur;
        exp_t e;
        c0 = cyc;
        cur = first;
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                req_i[i] = 1'b1;
                vd_i[i] = 5'(20 + i);
                nbeats_i[i] = 4'd1;
                beat_valid_i[i] = 1'b1;
                beat_data_i[i] = bdata(i, 0);
                beat_be_i[i] = bbe(i, 0);
            end
        end
        for (int j = 0; j < nb; j++) begin
            while (!mask[cur]) cur = (cur + 1) % 3;
            e = '{addr: 5'(20 + cur), data: bdata(cur, 0), be: bbe(cur, 0), src: 2'(cur), done: 1'b1, cyc: c0 + 2 + 2 * j};
            exp_q.push_back(e);
            cur = (cur + 1) % 3;
        end
        repeat (2 * nb) @(posedge clk);
        #1;
        req_i = '0;
        beat_valid_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rr_drained", exp_q.size(), 0);
    endtask

    initial begin
        exp_t e;
        tbl[0] = '{src: 0, vd: 5'd4,  nb: 4'd2, err: 1'b0};
        tbl[1] = '{src: 1, vd: 5'd30, nb: 4'd4, err: 1'b1};
        tbl[2] = '{src: 2, vd: 5'd0,  nb: 4'd0, err: 1'b1};
        tbl[3] = '{src: 2, vd: 5'd28, nb: 4'd4, err: 1'b0};
        tbl[4] = '{src: 1, vd: 5'd0,  nb: 4'd9, err: 1'b1};
        tbl[5] = '{src: 0, vd: 5'd31, nb: 4'd1, err: 1'b0};
        tbl[6] = '{src: 1, vd: 5'd24, nb: 4'd8, err: 1'b0};
        tbl[7] = '{src: 0, vd: 5'd25, nb: 4'd8, err: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        rr_seq(3'b111, 4, 0);

        for (int t = 0; t < 8; t++)
            run_burst(tbl[t].src, tbl[t].vd, tbl[t].nb, 16'hFFFF, tbl[t].err);

        run_burst(1, 5'd5, 4'd3, 16'b101001, 1'b0);
        run_burst(2, 5'd2, 4'd1, 16'hFFFF, 1'b0);

        // abort while idle blocks the grant but still reports the bad request
        req_i = 3'b110;
        vd_i[1] = 5'd0;
        nbeats_i[1] = 4'd1;
        vd_i[2] = 5'd0;
        nbeats_i[2] = 4'd0;
        abort_i = 1'b1;
        @(posedge clk); #1;
        req_i = '0;
        abort_i = 1'b0;
        chk("abort_idle_err", err_o, 3'b100);
        chk("abort_idle_busy", busy_o, 0);
        @(posedge clk); #1;

        // burst abort after one beat, with a scalar request waiting behind it
        req_i = 3'b101;
        vd_i[0] = 5'd12;
        nbeats_i[0] = 4'd4;
        vd_i[2] = 5'd8;
        nbeats_i[2] = 4'd1;
        beat_valid_i = 3'b101;
        beat_data_i[0] = bdata(0, 0);
        beat_be_i[0] = bbe(0, 0);
        beat_data_i[2] = bdata(2, 0);
        beat_be_i[2] = bbe(2, 0);
        @(posedge clk); #1;
        req_i[0] = 1'b0;
        @(negedge clk);
        chk("abort_ready_pre", beat_ready_o, 3'b001);
        e = '{addr: 5'd12, data: bdata(0, 0), be: bbe(0, 0), src: 2'd0, done: 1'b0, cyc: cyc + 1};
        exp_q.push_back(e);
        @(posedge clk); #1;
        abort_i = 1'b1;
        beat_data_i[0] = bdata(0, 1);
        @(negedge clk);
        chk("abort_ready", beat_ready_o, 0);
        chk("abort_busy", busy_o, 1);
        @(posedge clk); #1;
        abort_i = 1'b0;
        beat_valid_i[0] = 1'b0;
        @(negedge clk);
        chk("post_abort_idle", busy_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("scalar_ready", beat_ready_o, 3'b100);
        e = '{addr: 5'd8, data: bdata(2, 0), be: bbe(2, 0), src: 2'd2, done: 1'b1, cyc: cyc + 1};
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_i = '0;
        beat_valid_i = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset in the middle of a four-beat burst
        req_i[0] = 1'b1;
        vd_i[0] = 5'd16;
        nbeats_i[0] = 4'd4;
        beat_valid_i[0] = 1'b1;
        beat_data_i[0] = bdata(0, 0);
        beat_be_i[0] = bbe(0, 0);
        @(posedge clk); #1;
        req_i[0] = 1'b0;
        @(negedge clk);
        e = '{addr: 5'd16, data: bdata(0, 0), be: bbe(0, 0), src: 2'd0, done: 1'b0, cyc: cyc + 1};
        exp_q.push_back(e);
        @(posedge clk); #1;
        beat_data_i[0] = bdata(0, 1);
        beat_be_i[0] = bbe(0, 1);
        @(negedge clk);
        e = '{addr: 5'd17, data: bdata(0, 1), be: bbe(0, 1), src: 2'd0, done: 1'b0, cyc: cyc + 1};
        exp_q.push_back(e);
        @(posedge clk); #1;
        beat_valid_i[0] = 1'b0;
        @(negedge clk);
        chk("midburst_busy", busy_o, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rr_seq(3'b011, 2, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
